// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM states, default geometry and address helper for the MEM-stage responder
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mem_state_t;

   localparam int unsigned DEF_BASE_ADDR   = 1024;
   localparam int unsigned DEF_DEPTH       = 64;
   localparam int unsigned DEF_WAIT_CYCLES = 4;
   localparam int unsigned DEF_IDX_W       = $clog2(DEF_DEPTH);

   // Word offset from the window base; callers truncate to the index width, which is the mod-DEPTH wrap.
   function automatic logic [31:0] word_offset(input logic [31:0] byte_addr, input logic [31:0] base);
      return (byte_addr - base) >> 2;
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - synchronous-write, registered-read word RAM with a resettable read register
module mem_word_array
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned IDX_W = DEF_IDX_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_we,
   input  logic             i_re,
   input  logic             i_clr,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   // Storage is deliberately left without reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_clr) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage_responder.sv
// rtl/mem_stage_responder.sv - fixed-latency data-memory responder for the MEM stage; optional MEM_ALIGN_CHECK_EN adds err
module mem_stage_responder
   import mem_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
   parameter int unsigned DEPTH       = DEF_DEPTH,
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic        err
`endif
);

   localparam int unsigned IDX_W    = $clog2(DEPTH);
   localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

   mem_state_t       r_state;
   logic [3:0]       r_cnt;
   logic             r_is_wr;
   logic             r_collide;
   logic [IDX_W-1:0] r_idx;
   logic [31:0]      r_wdata;
   logic             w_fire;
   logic             w_ok;
   logic             w_we;
   logic             w_re;
   logic             w_clr;

`ifdef MEM_ALIGN_CHECK_EN
   logic r_misal;
   logic r_err;

   assign w_ok = ~r_misal;
   assign err  = r_err;
`else
   assign w_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_is_wr   <= 1'b0;
         r_collide <= 1'b0;
         r_idx     <= '0;
         r_wdata   <= '0;
`ifdef MEM_ALIGN_CHECK_EN
         r_misal   <= 1'b0;
         r_err     <= 1'b0;
`endif
      end else begin
`ifdef MEM_ALIGN_CHECK_EN
         r_err <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (rd_en | wr_en) begin
                  r_is_wr   <= wr_en;
                  r_collide <= rd_en & wr_en;
                  r_idx     <= IDX_W'(word_offset(addr, BASE_ADDR));
                  r_wdata   <= wdata;
                  r_cnt     <= CNT_INIT;
                  r_state   <= BUSY;
`ifdef MEM_ALIGN_CHECK_EN
                  r_misal   <= |addr[1:0];
`endif
               end
            end
            BUSY: begin
               if (r_cnt == 4'd0) begin
                  r_state <= DONE;
`ifdef MEM_ALIGN_CHECK_EN
                  r_err   <= r_misal;
`endif
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // The array access happens on the same edge that moves BUSY into DONE.
   assign w_fire = (r_state == BUSY) && (r_cnt == 4'd0);
   assign w_we   = w_fire & w_ok & r_is_wr;
   assign w_re   = w_fire & w_ok & ~r_is_wr;
   assign w_clr  = w_fire & w_ok & r_collide;

   assign ready = (r_state == DONE) | ((r_state == IDLE) & ~rd_en & ~wr_en);

   mem_word_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_clr   (w_clr),
      .i_idx   (r_idx),
      .i_wdata (r_wdata),
      .o_rdata (rdata)
   );

endmodule

// File: tb/tb_mem_stage_responder.sv
// tb/tb_mem_stage_responder.sv - randomized self-checking bench for mem_stage_responder against a transaction-level model
module tb_mem_stage_responder;

   localparam int unsigned BASE  = 1024;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned WAIT  = 4;

   logic        clk;
   logic        rst;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
`ifdef MEM_ALIGN_CHECK_EN
   logic        err;
`endif

   int checks;
   int errors;

   logic [31:0] mem_model [int];
   logic [31:0] exp_rdata;
   bit          exp_known;

   mem_stage_responder #(
      .BASE_ADDR   (BASE),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (WAIT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .rd_en (rd_en),
      .wr_en (wr_en),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .ready (ready)
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .err   (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete access as seen by the MEM stage; the model decides latency, data and err.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input bit drop);
      int n;
      int idx;
      bit misal;
      idx   = int'(((a - 32'(BASE)) >> 2) % DEPTH);
      misal = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misal = (a[1:0] != 2'b00);
`endif
      @(posedge clk);
      #1;
      rd_en = rd;
      wr_en = wr;
      addr  = a;
      wdata = d;
      #1;
      n = 0;
      while (!ready && n < 64) begin
         n++;
         if (drop && n == 2) begin
            rd_en = 1'b0;
            wr_en = 1'b0;
         end
         @(posedge clk);
         #2;
`ifdef MEM_ALIGN_CHECK_EN
         if (!ready) check_eq("err_busy", 32'(err), 32'd0);
`endif
      end
      check_eq("latency", 32'(n), 32'(WAIT + 1));
      if (!misal) begin
         if (wr) begin
            mem_model[idx] = d;
            if (rd) begin
               exp_rdata = 32'd0;
               exp_known = 1'b1;
            end
         end else if (mem_model.exists(idx)) begin
            exp_rdata = mem_model[idx];
            exp_known = 1'b1;
         end else begin
            exp_known = 1'b0;
         end
      end
      if (exp_known) check_eq("rdata_done", rdata, exp_rdata);
`ifdef MEM_ALIGN_CHECK_EN
      check_eq("err_done", 32'(err), 32'(misal));
`endif
      rd_en = 1'b0;
      wr_en = 1'b0;
      @(posedge clk);
      #2;
      check_eq("ready_idle", 32'(ready), 32'd1);
`ifdef MEM_ALIGN_CHECK_EN
      check_eq("err_idle", 32'(err), 32'd0);
`endif
   endtask

   initial begin
      logic [31:0] a;
      int k;
      int w;
      int op;
      checks    = 0;
      errors    = 0;
      exp_rdata = 32'd0;
      exp_known = 1'b1;
      rst   = 1'b0;
      rd_en = 1'b0;
      wr_en = 1'b0;
      addr  = 32'd0;
      wdata = 32'd0;
      repeat (3) @(posedge clk);
      #2;
      check_eq("reset_rdata", rdata, 32'd0);
      check_eq("reset_ready", 32'(ready), 32'd1);
`ifdef MEM_ALIGN_CHECK_EN
      check_eq("reset_err", 32'(err), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;

      do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
      do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
      do_access(1'b0, 1'b1, 32'(1024 + 4 * DEPTH), 32'h11, 1'b0);
      do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
      do_access(1'b1, 1'b1, 32'd1028, 32'h55, 1'b0);
      do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);

      // Abort a write with reset while it is in BUSY; the old word must survive.
      do_access(1'b0, 1'b1, 32'd1032, 32'h1234, 1'b0);
      do_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      wr_en = 1'b1;
      addr  = 32'd1032;
      wdata = 32'hAA;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_ready_req", 32'(ready), 32'd0);
      wr_en = 1'b0;
      #1;
      check_eq("rst_ready_idle", 32'(ready), 32'd1);
      exp_rdata = 32'd0;
      exp_known = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      do_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);

      do_access(1'b0, 1'b1, 32'd1036, 32'h77, 1'b1);
      do_access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
      do_access(1'b0, 1'b1, 32'd1026, 32'h99, 1'b0);
      do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
`endif

      for (int t = 0; t < 40; t++) begin
         k  = int'($urandom_range(0, 7));
         w  = int'($urandom_range(0, 2));
         op = int'($urandom_range(0, 3));
         a  = 32'(BASE + 4 * k + 4 * DEPTH * w) - 32'(4 * DEPTH);
`ifndef MEM_ALIGN_CHECK_EN
         a  = a + 32'($urandom_range(0, 3));
`endif
         do_access(op != 1, op != 0, a, $urandom, ($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_responder.md
# mem_stage_responder

Data-memory responder serving the MEM-stage load/store requests of the 5-stage pipeline. It accepts one read or write at a time, models a fixed-latency memory with an internal word array, and holds `ready` low to freeze the pipeline until the access completes. Read data reaches the MEM/WB pipeline register on the completion cycle.

## Interface
- `BASE_ADDR`, default 1024: byte address that maps to word 0.
- `DEPTH`, default 64: number of 32-bit words; power of two.
- `WAIT_CYCLES`, default 4: busy cycles per access; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `rd_en` input 1: load request from MEM stage.
- `wr_en` input 1: store request from MEM stage.
- `addr` input 32: byte address (ALU result).
- `wdata` input 32: store data.
- `rdata` output 32: load data, registered.
- `ready` output 1: high means no access is pending; low freezes all pipeline registers.
- `err` output 1: misaligned-access flag, registered. Present only with `MEM_ALIGN_CHECK_EN`.

## Operation
- FSM states: IDLE, BUSY, DONE. A 4-bit down-counter `cnt` runs the busy period.
- IDLE, with `rd_en|wr_en` high:
  - Latch op, address and `wdata`.
  - Load `cnt = WAIT_CYCLES-1` and go to BUSY.
  - If both enables are high, the access is a write; `rdata` is then 0 at DONE.
- IDLE with no request: stay in IDLE.
- BUSY: decrement `cnt`. When `cnt==0`, go to DONE and perform the access:
  - A write updates the array.
  - A read loads `rdata`.
- DONE: go to IDLE unconditionally.
- Word index = `((addr - BASE_ADDR) >> 2) mod DEPTH`, using 32-bit unsigned subtraction. Out-of-range addresses wrap; this is not an error.
- `ready` is combinational and equals `(state==DONE) | (state==IDLE & ~rd_en & ~wr_en)`.
- The latched request is authoritative. If the enables drop during BUSY, the access still completes (a write still commits).
- `rdata` holds its last value until the next read completes. It is zeroed only by reset or by a write-priority collision.
- The array has no reset; its contents are undefined after power-up.
- Asserting `rst` mid-operation:
  - Aborts the access; no write commits.
  - State goes to IDLE, `cnt=0`, `rdata=0`, `err=0`.

## Timing
- A request first seen in IDLE at cycle 0 has `ready=0` at cycle 0.
- BUSY spans cycles 1..`WAIT_CYCLES`.
- DONE occurs at cycle `WAIT_CYCLES+1`, with `ready=1` and `rdata` valid.
- Total freeze is `WAIT_CYCLES+1` cycles. The pipeline advances at the DONE edge.
- The MEM stage holds `rd_en`, `wr_en`, `addr` and `wdata` stable while `ready=0`.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE, so there is one idle gap.
- Reset output values: `rdata=0`, `err=0`. `ready` is 1 when no enable is high; otherwise it follows the IDLE rule above.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A request with `addr[1:0]!=0` is accepted and runs the full latency, but the array is not written and `rdata` is not updated.
  - `err` is 1 during DONE and 0 otherwise.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `addr[1:0]` is ignored; every access proceeds normally.
  - The `err` port and its logic are absent.

## Structure
- Shared package `mem_pkg` holds:
  - the FSM state enum (IDLE, BUSY, DONE);
  - the default `BASE_ADDR`, `DEPTH` and `WAIT_CYCLES` constants;
  - the word-index width, `$clog2(DEPTH)`.
- One sub-module is natural: `mem_word_array`, a synchronous-write, registered-read word RAM. The FSM and counter stay in the top module.

## Test plan
- Write then read, `WAIT_CYCLES=4`:
  - Write `addr=1024`, `wdata=32'hDEADBEEF`: `ready` is low for 5 cycles, then high.
  - Read `addr=1024`: `rdata=32'hDEADBEEF` on the DONE cycle.
- Wrap-around: write `32'h11` to `addr=1024+4*DEPTH`, then read `addr=1024` -> `rdata=32'h11`.
- Collision: `rd_en=wr_en=1`, `addr=1028`, `wdata=32'h55` -> `rdata=0` at DONE; a later read of 1028 returns `32'h55`.
- Reset mid-op: start a write of `32'hAA` to 1032, then pull `rst` low at cycle 2 -> state IDLE, `rdata=0`, and a later read of 1032 returns its prior value.
- Enables dropped during BUSY on a write of `32'h77` to 1036 -> the write commits and DONE still occurs at cycle 5.
- With `MEM_ALIGN_CHECK_EN`: write to `addr=1026` -> `err=1` for one cycle at DONE and the array is unchanged; an aligned access -> `err=0`.
